// File: rtl/greg_pkg.sv
// Shared constants, types and the write-port match helper for the greg_mp register file.
package greg_pkg;

    // Default geometry of the MIPS general register file.
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    // Index of the optionally hardwired-zero register.
    localparam int REG_ZERO = 0;

    // Upper bounds used by the match helper. Callers zero-extend their write
    // ports to these sizes, so NWR <= MAX_WR and ADDR_W <= MAX_ADDR_W must hold.
    localparam int MAX_WR     = 16;
    localparam int MAX_ADDR_W = 16;
    localparam int PORT_W     = 4;

    // Result of a write-port search: whether any port hits, and which one.
    typedef struct packed {
        logic              hit;
        logic [PORT_W-1:0] port;
    } wr_hit_t;

    // Find the highest-index enabled write port that targets idx. Later
    // matches overwrite earlier ones, which gives the higher port priority.
    function automatic wr_hit_t wr_match(
        input logic [MAX_WR-1:0]            en,
        input logic [MAX_WR*MAX_ADDR_W-1:0] nums,
        input logic [MAX_ADDR_W-1:0]        idx
    );
        wr_hit_t res;
        res.hit  = 1'b0;
        res.port = '0;
        for (int k = 0; k < MAX_WR; k++) begin
            if (en[k] && (nums[k*MAX_ADDR_W +: MAX_ADDR_W] == idx)) begin
                res.hit  = 1'b1;
                res.port = PORT_W'(k);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/greg_rd_port.sv
// One combinational read port: index decode, write bypass, zero override and busy lookup.
module greg_rd_port
    import greg_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DEPTH    = 2**ADDR_W,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                         rd_en,
    input  logic [ADDR_W-1:0]            rd_num,
    input  logic [DEPTH*DATA_W-1:0]      mem_flat,
    input  logic [DEPTH-1:0]             busy_vec,
    input  logic [MAX_WR-1:0]            wr_en_ext,
    input  logic [MAX_WR*MAX_ADDR_W-1:0] wr_num_ext,
    input  logic [NWR*DATA_W-1:0]        wr_data,
    input  logic                         busy_set,
    input  logic [ADDR_W-1:0]            busy_num,
    output logic [DATA_W-1:0]            rd_data,
    output logic                         rd_busy
);

    wr_hit_t hit;

    // Select stored value, then let a same-cycle write, r0 and reset override it in that order.
    always_comb begin
        hit     = wr_match(wr_en_ext, wr_num_ext, MAX_ADDR_W'(rd_num));
        rd_data = mem_flat[rd_num*DATA_W +: DATA_W];
        rd_busy = busy_vec[rd_num];

        // A write in flight means its producer is done; only a new issue to
        // the same register this cycle keeps it pending.
        if ((BYPASS != 0) && hit.hit) begin
            rd_data = wr_data[hit.port*DATA_W +: DATA_W];
            rd_busy = busy_set && (busy_num == rd_num);
        end

        if ((ZERO_REG != 0) && (rd_num == ADDR_W'(REG_ZERO))) begin
            rd_data = '0;
            rd_busy = 1'b0;
        end

        // Storage is already cleared in reset, but a bypassed write must not leak out.
        if (!rd_en) begin
            rd_data = '0;
            rd_busy = 1'b0;
        end
    end

endmodule

// File: rtl/greg_mp.sv
// Multi-port general register file with write arbitration, optional bypass,
// hardwired r0 and a per-register pending scoreboard.
module greg_mp
    import greg_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NWR-1:0]        wr_en,
    input  logic [NWR*ADDR_W-1:0] wr_num,
    input  logic [NWR*DATA_W-1:0] wr_data,
    input  logic [NRD*ADDR_W-1:0] rd_num,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic                  busy_set,
    input  logic [ADDR_W-1:0]     busy_num
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;

    logic [DEPTH*DATA_W-1:0]      mem_flat;
    logic [MAX_WR-1:0]            wr_en_ext;
    logic [MAX_WR*MAX_ADDR_W-1:0] wr_num_ext;

    // Widen the write ports to the fixed shape the match helper expects; unused slots never hit.
    generate
        for (genvar gi = 0; gi < MAX_WR; gi++) begin : g_wr_ext
            if (gi < NWR) begin : g_used
                assign wr_en_ext[gi] = wr_en[gi];
                assign wr_num_ext[gi*MAX_ADDR_W +: MAX_ADDR_W] =
                    MAX_ADDR_W'(wr_num[gi*ADDR_W +: ADDR_W]);
            end else begin : g_unused
                assign wr_en_ext[gi] = 1'b0;
                assign wr_num_ext[gi*MAX_ADDR_W +: MAX_ADDR_W] = '0;
            end
        end
    endgenerate

    // Flatten storage so each read port can index it as one vector.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_flat
            assign mem_flat[gi*DATA_W +: DATA_W] = mem_q[gi];
        end
    endgenerate

    // Next-state for data and scoreboard: ports in ascending order so the
    // highest enabled port wins a conflict; a new issue beats a completing write.
    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        for (int k = 0; k < NWR; k++) begin
            if (wr_en[k]) begin
                mem_d[wr_num[k*ADDR_W +: ADDR_W]]  = wr_data[k*DATA_W +: DATA_W];
                busy_d[wr_num[k*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (busy_set) begin
            busy_d[busy_num] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            mem_d[REG_ZERO]  = '0;
            busy_d[REG_ZERO] = 1'b0;
        end
    end

    // Register storage and scoreboard; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    // One read port instance per requested read port.
    generate
        for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
            greg_rd_port #(
                .DATA_W   (DATA_W),
                .ADDR_W   (ADDR_W),
                .DEPTH    (DEPTH),
                .NWR      (NWR),
                .ZERO_REG (ZERO_REG),
                .BYPASS   (BYPASS)
            ) u_rd_port (
                .rd_en      (rst_n),
                .rd_num     (rd_num[gi*ADDR_W +: ADDR_W]),
                .mem_flat   (mem_flat),
                .busy_vec   (busy_q),
                .wr_en_ext  (wr_en_ext),
                .wr_num_ext (wr_num_ext),
                .wr_data    (wr_data),
                .busy_set   (busy_set),
                .busy_num   (busy_num),
                .rd_data    (rd_data[gi*DATA_W +: DATA_W]),
                .rd_busy    (rd_busy[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_greg_mp.sv
// Directed vector bench for greg_mp: default build (a), ZERO_REG=0 build (z), BYPASS=0 build (b).
module tb_greg_mp;

    logic        clk;
    logic        rst_n;
    logic [1:0]  wr_en;
    logic [9:0]  wr_num;
    logic [63:0] wr_data;
    logic [9:0]  rd_num;
    logic        busy_set;
    logic [4:0]  busy_num;

    logic [63:0] rd_data_a, rd_data_z, rd_data_b;
    logic [1:0]  rd_busy_a, rd_busy_z, rd_busy_b;

    int total = 0;
    int bad   = 0;

    greg_mp dut_a (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_num(wr_num), .wr_data(wr_data),
        .rd_num(rd_num), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .busy_set(busy_set), .busy_num(busy_num)
    );

    greg_mp #(.ZERO_REG(0)) dut_z (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_num(wr_num), .wr_data(wr_data),
        .rd_num(rd_num), .rd_data(rd_data_z), .rd_busy(rd_busy_z),
        .busy_set(busy_set), .busy_num(busy_num)
    );

    greg_mp #(.BYPASS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_num(wr_num), .wr_data(wr_data),
        .rd_num(rd_num), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .busy_set(busy_set), .busy_num(busy_num)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  en;
        logic [4:0]  n0, n1;
        logic [31:0] d0, d1;
        logic [4:0]  r0, r1;
        logic        bs;
        logic [4:0]  bn;
        logic [31:0] a0, a1;   // dut_a read data, ports 0/1
        logic [1:0]  ab;       // dut_a rd_busy
        logic [31:0] z0;       // dut_z port 0 data
        logic [31:0] b0;       // dut_b port 0 data
        logic        bb0;      // dut_b port 0 busy
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %h want %h", nm, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        wr_en    = v.en;
        wr_num   = {v.n1, v.n0};
        wr_data  = {v.d1, v.d0};
        rd_num   = {v.r1, v.r0};
        busy_set = v.bs;
        busy_num = v.bn;
    endtask

    task automatic idle();
        wr_en    = 2'b00;
        wr_num   = '0;
        wr_data  = '0;
        busy_set = 1'b0;
        busy_num = '0;
    endtask

    initial begin
        //            en     n0     n1     d0            d1            r0     r1     bs    bn     a0            a1            ab     z0            b0            bb0
        vecs[0]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        5'd0,  5'd1,  1'b0, 5'd0,  32'h0,        32'h0,        2'b00, 32'h0,        32'h0,        1'b0};
        vecs[1]  = '{2'b01, 5'd0,  5'd0,  32'd2333,     32'h0,        5'd0,  5'd1,  1'b0, 5'd0,  32'h0,        32'h0,        2'b00, 32'd2333,     32'h0,        1'b0};
        vecs[2]  = '{2'b01, 5'd1,  5'd0,  32'd2333,     32'h0,        5'd0,  5'd2,  1'b0, 5'd0,  32'h0,        32'h0,        2'b00, 32'd2333,     32'h0,        1'b0};
        vecs[3]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        5'd1,  5'd2,  1'b0, 5'd0,  32'd2333,     32'h0,        2'b00, 32'd2333,     32'd2333,     1'b0};
        vecs[4]  = '{2'b11, 5'd5,  5'd5,  32'h11,       32'h22,       5'd5,  5'd1,  1'b0, 5'd0,  32'h22,       32'd2333,     2'b00, 32'h22,       32'h0,        1'b0};
        vecs[5]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        5'd5,  5'd5,  1'b0, 5'd0,  32'h22,       32'h22,       2'b00, 32'h22,       32'h22,       1'b0};
        vecs[6]  = '{2'b01, 5'd7,  5'd0,  32'hABCD,     32'h0,        5'd7,  5'd5,  1'b0, 5'd0,  32'hABCD,     32'h22,       2'b00, 32'hABCD,     32'h0,        1'b0};
        vecs[7]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        5'd7,  5'd7,  1'b0, 5'd0,  32'hABCD,     32'hABCD,     2'b00, 32'hABCD,     32'hABCD,     1'b0};
        vecs[8]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        5'd3,  5'd7,  1'b1, 5'd3,  32'h0,        32'hABCD,     2'b00, 32'h0,        32'h0,        1'b0};
        vecs[9]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        5'd3,  5'd3,  1'b0, 5'd0,  32'h0,        32'h0,        2'b11, 32'h0,        32'h0,        1'b1};
        vecs[10] = '{2'b01, 5'd3,  5'd0,  32'h33,       32'h0,        5'd3,  5'd3,  1'b1, 5'd3,  32'h33,       32'h33,       2'b11, 32'h33,       32'h0,        1'b1};
        vecs[11] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        5'd3,  5'd0,  1'b0, 5'd0,  32'h33,       32'h0,        2'b01, 32'h33,       32'h33,       1'b1};
        vecs[12] = '{2'b10, 5'd0,  5'd3,  32'h0,        32'h44,       5'd3,  5'd3,  1'b0, 5'd0,  32'h44,       32'h44,       2'b00, 32'h44,       32'h33,       1'b1};
        vecs[13] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        5'd3,  5'd3,  1'b0, 5'd0,  32'h44,       32'h44,       2'b00, 32'h44,       32'h44,       1'b0};
        vecs[14] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        5'd0,  5'd0,  1'b1, 5'd0,  32'h0,        32'h0,        2'b00, 32'd2333,     32'h0,        1'b0};
        vecs[15] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        5'd0,  5'd0,  1'b0, 5'd0,  32'h0,        32'h0,        2'b00, 32'd2333,     32'h0,        1'b0};
        vecs[16] = '{2'b10, 5'd0,  5'd31, 32'h0,        32'hFFFFFFFF, 5'd31, 5'd30, 1'b0, 5'd0,  32'hFFFFFFFF, 32'h0,        2'b00, 32'hFFFFFFFF, 32'h0,        1'b0};
        vecs[17] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        5'd31, 5'd31, 1'b0, 5'd0,  32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};

        rst_n  = 1'b0;
        rd_num = '0;
        idle();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Table: drive after the falling edge, sample combinational outputs
        // before the next rising edge, which then commits the vector.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            apply(vecs[i]);
            #2;
            $display("step %0d: en=%b wn=%0d/%0d rd=%0d/%0d bs=%b/%0d a=%h/%h ab=%b z0=%h b0=%h bb0=%b",
                     i, vecs[i].en, vecs[i].n0, vecs[i].n1, vecs[i].r0, vecs[i].r1, vecs[i].bs, vecs[i].bn,
                     rd_data_a[31:0], rd_data_a[63:32], rd_busy_a, rd_data_z[31:0], rd_data_b[31:0], rd_busy_b[0]);
            chk("a_rd0",   i, rd_data_a[31:0],  vecs[i].a0);
            chk("a_rd1",   i, rd_data_a[63:32], vecs[i].a1);
            chk("a_busy",  i, {30'd0, rd_busy_a}, {30'd0, vecs[i].ab});
            chk("z_rd0",   i, rd_data_z[31:0],  vecs[i].z0);
            chk("b_rd0",   i, rd_data_b[31:0],  vecs[i].b0);
            chk("b_busy0", i, {31'd0, rd_busy_b[0]}, {31'd0, vecs[i].bb0});
        end

        // Mark r31 pending so reset has live data and a busy bit to clear.
        @(negedge clk);
        idle();
        busy_set = 1'b1;
        busy_num = 5'd31;
        @(negedge clk);
        idle();
        rd_num = {5'd3, 5'd31};
        #1;
        $display("pre-reset: a=%h ab=%b", rd_data_a[31:0], rd_busy_a);
        chk("pre_rst_rd0",  100, rd_data_a[31:0], 32'hFFFFFFFF);
        chk("pre_rst_busy", 100, {30'd0, rd_busy_a}, 32'd1);

        // Asynchronous reset with a write and a busy set pending: outputs go
        // to zero before any clock edge and stay there through one.
        rst_n    = 1'b0;
        wr_en    = 2'b01;
        wr_num   = {5'd0, 5'd31};
        wr_data  = {32'h0, 32'h55};
        busy_set = 1'b1;
        busy_num = 5'd31;
        #1;
        $display("in reset: a=%h/%h ab=%b z0=%h b0=%h", rd_data_a[31:0], rd_data_a[63:32], rd_busy_a, rd_data_z[31:0], rd_data_b[31:0]);
        chk("rst_a_rd0",  101, rd_data_a[31:0],  32'h0);
        chk("rst_a_rd1",  101, rd_data_a[63:32], 32'h0);
        chk("rst_a_busy", 101, {30'd0, rd_busy_a}, 32'd0);
        chk("rst_z_rd0",  101, rd_data_z[31:0],  32'h0);
        chk("rst_b_rd0",  101, rd_data_b[31:0],  32'h0);
        @(posedge clk);
        #1;
        $display("reset edge: a=%h ab=%b", rd_data_a[31:0], rd_busy_a);
        chk("rst_edge_rd0",  102, rd_data_a[31:0], 32'h0);
        chk("rst_edge_busy", 102, {30'd0, rd_busy_a}, 32'd0);

        // After release the discarded write and busy set must not appear.
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        #1;
        $display("post-reset: a=%h ab=%b b0=%h", rd_data_a[31:0], rd_busy_a, rd_data_b[31:0]);
        chk("post_rst_rd0",  103, rd_data_a[31:0], 32'h0);
        chk("post_rst_busy", 103, {30'd0, rd_busy_a}, 32'd0);
        chk("post_rst_b0",   103, rd_data_b[31:0], 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
